// File: rtl/pulse_to_level.sv
// Turns single-cycle event pulses into fixed-width high pulses, each followed by a low gap.
// Events that arrive while a pulse or gap is running are counted and replayed back-to-back.
module pulse_to_level #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w,
  output logic              z,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              z_q, z_d;
  logic              overflow_q, overflow_d;
  logic              consume;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      z_q        <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      z_q        <= z_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    consume    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (w) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          // An event arriving on this very edge counts toward the replay decision.
          if (pending_q != '0 || w) begin
            consume = 1'b1;
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Queue bookkeeping only applies while a pulse or gap is in flight.
    if (state_q != IDLE && w) begin
      if (!consume) begin
        if (pending_q == PEND_MAX) overflow_d = 1'b1;
        else                       pending_d  = pending_q + 1'b1;
      end
    end else if (consume) begin
      pending_d = pending_q - 1'b1;
    end

    z_d = (state_d == HOLD);
  end

  assign z        = z_q;
  assign busy     = (state_q != IDLE);
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule
